// File: rtl/fp_pkg.sv
// Shared constants for the FP add/sub back end: field widths, special-value encodings, sum bit positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

  localparam int EXPONENT_WIDTH    = 8;
  localparam int SIGNIFICAND_WIDTH = 23;
  localparam int TOTAL_WIDTH       = 1 + EXPONENT_WIDTH + SIGNIFICAND_WIDTH;
  localparam int SUM_WIDTH         = SIGNIFICAND_WIDTH + 6;

  // Low-order sum fields sit at fixed positions regardless of the fraction width
  localparam int SUM_S_BIT    = 0;
  localparam int SUM_R_BIT    = 1;
  localparam int SUM_G_BIT    = 2;
  localparam int SUM_FRAC_LSB = 3;

  // High-order sum fields for the default fraction width
  localparam int SUM_HIDDEN_BIT = SIGNIFICAND_WIDTH + 3;
  localparam int SUM_CARRY_BIT  = SIGNIFICAND_WIDTH + 4;
  localparam int SUM_SIGN_BIT   = SIGNIFICAND_WIDTH + 5;

  // Special-value encodings
  localparam logic [EXPONENT_WIDTH-1:0] EXP_INF = '1;
  localparam logic [EXPONENT_WIDTH-1:0] EXP_NAN = '1;
  localparam logic [TOTAL_WIDTH-1:0] CANONICAL_NAN =
    {1'b0, EXP_NAN, 1'b1, {(SIGNIFICAND_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fp_leading_zero_count.sv
// Leading-zero counter: number of zeros above the most significant set bit (WIDTH when input is zero).
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of the input.
module fp_leading_zero_count #(
  parameter int WIDTH       = 28,
  parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]       i_value,
  output logic [COUNT_WIDTH-1:0] o_count
);

  // Scan upward so the highest set bit is the last one to write the count
  always_comb begin
    o_count = COUNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_value[i]) begin
        o_count = COUNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_normalize_pack.sv
// FP add/sub back end: sum magnitude, normalise, optional RNE rounding (FP_NORMALIZE_ROUND_EN), pack IEEE result.
// Latency: 2 cycles input to result_o, one beat per cycle.
// Backpressure: both stages hold while valid_o is high and ready_i is low; ready_o mirrors that advance.
module fp_normalize_pack #(
  parameter int EXPONENT_WIDTH    = fp_pkg::EXPONENT_WIDTH,
  parameter int SIGNIFICAND_WIDTH = fp_pkg::SIGNIFICAND_WIDTH,
  parameter int TOTAL_WIDTH       = 1 + EXPONENT_WIDTH + SIGNIFICAND_WIDTH,
  parameter int SUM_WIDTH         = SIGNIFICAND_WIDTH + 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [SUM_WIDTH-1:0]      significand_i,
  input  logic [EXPONENT_WIDTH-1:0] exponent_i,
  input  logic                      result_is_inf_i,
  input  logic                      result_is_nan_i,
  input  logic                      inf_sign_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [TOTAL_WIDTH-1:0]    result_o
);
  import fp_pkg::*;

  localparam int MW       = SIGNIFICAND_WIDTH + 5;          // magnitude: carry, hidden, fraction, G, R, S
  localparam int CW       = $clog2(MW + 1);
  localparam int EXW      = EXPONENT_WIDTH + 2;             // signed exponent working width
  localparam int SIGN_BIT = SIGNIFICAND_WIDTH + 5;
  localparam int HID_BIT  = SIGNIFICAND_WIDTH + SUM_FRAC_LSB;
  localparam int MANT_W   = SIGNIFICAND_WIDTH + 1;          // hidden + fraction
  localparam int RW       = MANT_W + 1;                     // plus rounding carry-out

  localparam logic signed [EXW-1:0] EXP_ZERO_S = '0;
  localparam logic signed [EXW-1:0] EXP_ONES_S = EXW'((1 << EXPONENT_WIDTH) - 1);

  // ---------------- flow control ----------------
  logic w_advance;
  logic r_out_vld;
  logic [TOTAL_WIDTH-1:0] r_result;

  assign w_advance = ~r_out_vld | ready_i;
  assign ready_o   = w_advance;
  assign valid_o   = r_out_vld;
  assign result_o  = r_result;

  // ---------------- stage A: magnitude and leading-zero count ----------------
  logic                 w_sum_sign;
  logic [SUM_WIDTH-1:0] w_mag_full;
  logic [MW-1:0]        w_mag;
  logic [CW-1:0]        w_lzc;

  assign w_sum_sign = significand_i[SIGN_BIT];
  assign w_mag_full = w_sum_sign ? -significand_i : significand_i;
  assign w_mag      = w_mag_full[MW-1:0];

  fp_leading_zero_count #(
    .WIDTH       (MW),
    .COUNT_WIDTH (CW)
  ) u_lzc (
    .i_value (w_mag),
    .o_count (w_lzc)
  );

  logic                      r_a_vld;
  logic                      r_a_sign;
  logic [MW-1:0]             r_a_mag;
  logic [CW-1:0]             r_a_lzc;
  logic [EXPONENT_WIDTH-1:0] r_a_exp;
  logic                      r_a_nan;
  logic                      r_a_inf;
  logic                      r_a_inf_sign;

  // Stage A register: only the valid bit needs a reset, data is qualified by it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a_vld <= 1'b0;
    end else if (w_advance) begin
      r_a_vld      <= valid_i;
      r_a_sign     <= w_sum_sign;
      r_a_mag      <= w_mag;
      r_a_lzc      <= w_lzc;
      r_a_exp      <= exponent_i;
      r_a_nan      <= result_is_nan_i;
      r_a_inf      <= result_is_inf_i;
      r_a_inf_sign <= inf_sign_i;
    end
  end

  // ---------------- stage B: normalise, round, pack ----------------
  logic [MW-1:0]            w_norm;
  logic [CW-1:0]            w_lshift;
  logic signed [EXW-1:0]    w_exp_norm;
  logic                     w_round_inc;
  logic [MANT_W-1:0]        w_mant;
  logic [RW-1:0]            w_round;
  logic [SIGNIFICAND_WIDTH-1:0] w_frac;
  logic signed [EXW-1:0]    w_exp_fin;
  logic [TOTAL_WIDTH-1:0]   w_result;
  logic                     w_unused;

  // Bring the hidden bit to its nominal position: carry set shifts right, otherwise shift left
  always_comb begin
    w_norm     = '0;
    w_lshift   = '0;
    w_exp_norm = '0;
    if (r_a_lzc == '0) begin
      // The bit dropped off the bottom must survive as sticky
      w_norm            = {1'b0, r_a_mag[MW-1:1]};
      w_norm[SUM_S_BIT] = r_a_mag[1] | r_a_mag[0];
      w_exp_norm        = EXW'(r_a_exp) + EXW'(1);
    end else begin
      w_lshift   = r_a_lzc - CW'(1);
      w_norm     = r_a_mag << w_lshift;
      w_exp_norm = EXW'(r_a_exp) - EXW'(w_lshift);
    end
  end

`ifdef FP_NORMALIZE_ROUND_EN
  assign w_round_inc = w_norm[SUM_G_BIT] &
                       (w_norm[SUM_R_BIT] | w_norm[SUM_S_BIT] | w_norm[SUM_FRAC_LSB]);
  assign w_unused    = ^{w_mag_full[SIGN_BIT], w_norm[MW-1]};
`else
  assign w_round_inc = 1'b0;
  assign w_unused    = ^{w_mag_full[SIGN_BIT], w_norm[MW-1],
                         w_norm[SUM_G_BIT], w_norm[SUM_R_BIT], w_norm[SUM_S_BIT]};
`endif

  assign w_mant  = w_norm[HID_BIT:SUM_FRAC_LSB];
  assign w_round = {1'b0, w_mant} + RW'(w_round_inc);
  // A rounding carry-out means the mantissa became 10.000..., so renormalise by one
  assign w_frac    = w_round[MANT_W] ? w_round[MANT_W-1:1] : w_round[MANT_W-2:0];
  assign w_exp_fin = w_exp_norm + EXW'(w_round[MANT_W]);

  // Special values first, then exponent range limits, then the ordinary packed result
  always_comb begin
    w_result = '0;
    if (r_a_nan) begin
      w_result = {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(SIGNIFICAND_WIDTH-1){1'b0}}};
    end else if (r_a_inf) begin
      w_result = {r_a_inf_sign, {EXPONENT_WIDTH{1'b1}}, {SIGNIFICAND_WIDTH{1'b0}}};
    end else if (r_a_mag == '0) begin
      w_result = '0;
    end else if (w_exp_fin >= EXP_ONES_S) begin
      w_result = {r_a_sign, {EXPONENT_WIDTH{1'b1}}, {SIGNIFICAND_WIDTH{1'b0}}};
    end else if (w_exp_fin <= EXP_ZERO_S) begin
      w_result = {r_a_sign, {EXPONENT_WIDTH{1'b0}}, {SIGNIFICAND_WIDTH{1'b0}}};
    end else begin
      w_result = {r_a_sign, w_exp_fin[EXPONENT_WIDTH-1:0], w_frac};
    end
  end

  // Output register: result only updates on a real beat so it stays stable between beats
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_vld <= 1'b0;
      r_result  <= '0;
    end else if (w_advance) begin
      r_out_vld <= r_a_vld;
      if (r_a_vld) begin
        r_result <= w_result;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Bench for fp_normalize_pack: directed beats, scoreboard of expected packed results, stall and reset cases.
// Latency: expects 2-cycle pipeline, results checked in order as they leave.
// Backpressure: drives ready_i low to exercise holding, checks ready_o and result stability.
module tb_fp_normalize_pack;
  import fp_pkg::*;

  localparam int SW = SUM_WIDTH;
  localparam int TW = TOTAL_WIDTH;

  localparam logic [SW-1:0] B_C    = SW'(1) << SUM_CARRY_BIT;
  localparam logic [SW-1:0] B_H    = SW'(1) << SUM_HIDDEN_BIT;
  localparam logic [SW-1:0] B_LSB  = SW'(1) << SUM_FRAC_LSB;
  localparam logic [SW-1:0] B_G    = SW'(1) << SUM_G_BIT;
  localparam logic [SW-1:0] B_R    = SW'(1) << SUM_R_BIT;
  localparam logic [SW-1:0] F_ONES = ((SW'(1) << SIGNIFICAND_WIDTH) - SW'(1)) << SUM_FRAC_LSB;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      valid_i;
  logic                      ready_o;
  logic [SW-1:0]             significand_i;
  logic [EXPONENT_WIDTH-1:0] exponent_i;
  logic                      result_is_inf_i;
  logic                      result_is_nan_i;
  logic                      inf_sign_i;
  logic                      valid_o;
  logic                      ready_i;
  logic [TW-1:0]             result_o;

  always #5 clk = ~clk;

  fp_normalize_pack dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .significand_i   (significand_i),
    .exponent_i      (exponent_i),
    .result_is_inf_i (result_is_inf_i),
    .result_is_nan_i (result_is_nan_i),
    .inf_sign_i      (inf_sign_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .result_o        (result_o)
  );

  logic [TW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_in     = 0;
  int n_out    = 0;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Output monitor: every transfer out pops the oldest expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", TW'(exp_q.size()), TW'(1));
      end else begin
        n_out++;
        check($sformatf("beat%0d", n_out), result_o, exp_q.pop_front());
      end
    end
  end

  // Present one beat and wait (bounded) for it to be accepted
  task automatic send(input string tag, input logic [SW-1:0] sig, input logic [EXPONENT_WIDTH-1:0] e,
                      input logic nan, input logic inf, input logic isg, input logic [TW-1:0] expv);
    int budget;
    budget          = 0;
    valid_i         = 1'b1;
    significand_i   = sig;
    exponent_i      = e;
    result_is_nan_i = nan;
    result_is_inf_i = inf;
    inf_sign_i      = isg;
    @(negedge clk);
    while (ready_o !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (ready_o !== 1'b1) begin
      check({tag, "_accept"}, TW'(ready_o), TW'(1));
    end else begin
      exp_q.push_back(expv);
      n_in++;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  // Wait (bounded) until every expected result has come out
  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    check(tag, TW'(exp_q.size()), TW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] t;
    reset_n         = 1'b0;
    valid_i         = 1'b0;
    significand_i   = '0;
    exponent_i      = '0;
    result_is_nan_i = 1'b0;
    result_is_inf_i = 1'b0;
    inf_sign_i      = 1'b0;
    ready_i         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_o", TW'(valid_o), TW'(0));
    check("rst_result_o", result_o, TW'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", TW'(ready_o), TW'(1));
    @(posedge clk);
    #1;

    // Main function, back-to-back beats
    send("one_plus_one", B_C, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h40000000);
    send("cancel",       '0,  8'h85, 1'b0, 1'b0, 1'b0, 32'h00000000);
    t = -(B_H | (B_H >> 1));
    send("neg_1p5",      t,   8'h7F, 1'b0, 1'b0, 1'b0, 32'hBFC00000);
    send("nan_and_inf",  B_C, 8'h7F, 1'b1, 1'b1, 1'b0, CANONICAL_NAN);
    send("inf_neg",      '0,  8'h10, 1'b0, 1'b1, 1'b1, 32'hFF800000);
    send("ovf_carry",    B_C, 8'hFE, 1'b0, 1'b0, 1'b0, 32'h7F800000);
    send("max_finite",   B_H, 8'hFE, 1'b0, 1'b0, 1'b0, 32'h7F000000);
    send("big_lshift",   B_LSB, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h34000000);
    send("exp_one",      B_LSB, 8'h18, 1'b0, 1'b0, 1'b0, 32'h00800000);
    send("exp_zero_ftz", B_LSB, 8'h17, 1'b0, 1'b0, 1'b0, 32'h00000000);
    t = -B_LSB;
    send("neg_ftz",      t,   8'h10, 1'b0, 1'b0, 1'b0, 32'h80000000);
    t = -B_C;
    send("neg_carry",    t,   8'h80, 1'b0, 1'b0, 1'b0, 32'hC0800000);
    send("tie_even",     B_H | B_G, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h3F800000);
`ifdef FP_NORMALIZE_ROUND_EN
    send("round_lsb_g",  B_H | B_LSB | B_G, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h3F800002);
    send("round_carry",  B_H | F_ONES | B_G | B_R, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h40000000);
    send("round_ovf",    B_H | F_ONES | B_G | B_R, 8'hFE, 1'b0, 1'b0, 1'b0, 32'h7F800000);
    send("carry_sticky", B_C | (B_LSB << 1) | B_LSB, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h40000002);
`else
    send("round_lsb_g",  B_H | B_LSB | B_G, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h3F800001);
    send("round_carry",  B_H | F_ONES | B_G | B_R, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h3FFFFFFF);
    send("round_ovf",    B_H | F_ONES | B_G | B_R, 8'hFE, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF);
    send("carry_sticky", B_C | (B_LSB << 1) | B_LSB, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h40000001);
`endif
    drain("drain_main");

    // Backpressure: three beats back to back with the consumer stalled
    ready_i = 1'b0;
    send("bp0", B_H, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h3F800000);
    send("bp1", B_C, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h40000000);
    t = -B_H;
    valid_i         = 1'b1;
    significand_i   = t;
    exponent_i      = 8'h80;
    result_is_nan_i = 1'b0;
    result_is_inf_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready_low", TW'(ready_o), TW'(0));
      check("bp_valid_held", TW'(valid_o), TW'(1));
      check("bp_result_held", result_o, 32'h3F800000);
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_ready_release", TW'(ready_o), TW'(1));
    exp_q.push_back(32'hC0000000);
    n_in++;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    drain("drain_bp");
    check("bp_in_out_count", TW'(n_out), TW'(n_in));

    // Reset in the middle of a stall discards everything in flight
    ready_i = 1'b0;
    send("rs0", B_H, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h3F800000);
    send("rs1", B_C, 8'h7F, 1'b0, 1'b0, 1'b0, 32'h40000000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    n_in    = n_in - exp_q.size();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid_o", TW'(valid_o), TW'(0));
    check("midrst_result_o", result_o, TW'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    check("midrst_ready", TW'(ready_o), TW'(1));
    @(posedge clk);
    #1;
    send("post_rst", B_C, 8'h80, 1'b0, 1'b0, 1'b0, 32'h40800000);
    drain("drain_post_rst");
    check("final_in_out_count", TW'(n_out), TW'(n_in));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
